// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default IM geometry and CPU run-state codes.
// The state codes are the values fetch decodes on curr_state.
package imem_loader_pkg;

  localparam int IM_ADDR_W = 8;
  localparam int IM_DATA_W = 32;
  localparam int IM_DEPTH  = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOAD = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

endpackage

// File: rtl/imem_loader_checksum.sv
// imem_checksum: 32-bit running sum (mod 2^32) of words written to IM, with clear and compare.
// Only instantiated when IMEM_CHECKSUM_EN is defined.
module imem_checksum
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = IM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] expected,
  output logic              match
);

  logic [DATA_W-1:0] sum_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg <= '0;
    end else if (clr) begin
      sum_reg <= '0;
    end else if (add) begin
      sum_reg <= sum_reg + data;
    end
  end

  assign match = (sum_reg == expected);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a host program into instruction memory over valid/ready, then releases the CPU (RUN).
// Optional feature macro: IMEM_CHECKSUM_EN (trailing checksum beat verified before RUN).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DATA_W = IM_DATA_W,
  parameter int DEPTH  = IM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  output logic              im_wea,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_din,
  output logic [1:0]        curr_state,
  output logic [ADDR_W:0]   word_count,
  output logic              load_err
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              wea_reg, wea_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] din_reg, din_next;
  logic              err_reg, err_next;
  logic              accept;

`ifdef IMEM_CHECKSUM_EN
  logic cks_phase_reg, cks_phase_next;
  logic sum_clr, sum_add, sum_match;

  imem_checksum #(.DATA_W(DATA_W)) u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clr      (sum_clr),
    .add      (sum_add),
    .data     (host_data),
    .expected (host_data),
    .match    (sum_match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cks_phase_reg <= 1'b0;
    else     cks_phase_reg <= cks_phase_next;
  end
`endif

  assign host_ready = (state_reg == ST_LOAD);
  assign accept     = host_valid & host_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      count_reg <= '0;
      wea_reg   <= 1'b0;
      addr_reg  <= '0;
      din_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
      wea_reg   <= wea_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    wea_next   = 1'b0;
    addr_next  = addr_reg;
    din_next   = din_reg;
    err_next   = err_reg;
`ifdef IMEM_CHECKSUM_EN
    cks_phase_next = cks_phase_reg;
    sum_clr        = 1'b0;
    sum_add        = 1'b0;
`endif
    case (state_reg)
      ST_LOAD: begin
        // start_load is deliberately not decoded here: a reload can't restart mid-stream.
        if (accept) begin
`ifdef IMEM_CHECKSUM_EN
          if (cks_phase_reg) begin
            cks_phase_next = 1'b0;
            state_next     = sum_match ? ST_RUN : ST_ERR;
            err_next       = ~sum_match;
          end else begin
`endif
            wea_next  = 1'b1;
            addr_next = ptr_reg;
            din_next  = host_data;
            ptr_next  = ptr_reg + 1'b1;
            if (count_reg != (ADDR_W+1)'(DEPTH)) count_next = count_reg + 1'b1;
`ifdef IMEM_CHECKSUM_EN
            sum_add = 1'b1;
            if (host_last) begin
              cks_phase_next = 1'b1;
            end else if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
              state_next = ST_ERR;
              err_next   = 1'b1;
            end
          end
`else
            if (host_last) begin
              state_next = ST_RUN;
            end else if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
              state_next = ST_ERR;
              err_next   = 1'b1;
            end
`endif
        end
      end
      default: begin
        // IDLE, RUN and ERR all restart a fresh load from address 0.
        if (start_load) begin
          state_next = ST_LOAD;
          ptr_next   = '0;
          count_next = '0;
          err_next   = 1'b0;
`ifdef IMEM_CHECKSUM_EN
          cks_phase_next = 1'b0;
          sum_clr        = 1'b1;
`endif
        end
      end
    endcase
  end

  assign im_wea     = wea_reg;
  assign im_addr    = addr_reg;
  assign im_din     = din_reg;
  assign curr_state = state_reg;
  assign word_count = count_reg;
  assign load_err   = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader: load/run cycles, throttled beats, overflow to ERR,
// async reset mid-stream, and (with IMEM_CHECKSUM_EN) checksum pass/fail.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_load, host_valid, host_ready, host_last;
  logic [31:0] host_data;
  logic        im_wea;
  logic [7:0]  im_addr;
  logic [31:0] im_din;
  logic [1:0]  curr_state;
  logic [8:0]  word_count;
  logic        load_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_data  (host_data),
    .host_last  (host_last),
    .im_wea     (im_wea),
    .im_addr    (im_addr),
    .im_din     (im_din),
    .curr_state (curr_state),
    .word_count (word_count),
    .load_err   (load_err)
  );

  typedef struct {
    logic        s, v, l;
    logic [31:0] d;
    logic        wea;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [1:0]  st;
    logic [8:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic v, logic l, logic [31:0] d, logic wea,
                              logic [7:0] addr, logic [1:0] st, logic [8:0] cnt);
    vec_t r;
    r.s = s; r.v = v; r.l = l; r.d = d;
    r.wea = wea; r.addr = addr; r.din = d; r.st = st; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic s, input logic v, input logic l, input logic [31:0] d);
    @(negedge clk);
    start_load = s; host_valid = v; host_last = l; host_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start_load = 1'b0; host_valid = 1'b0; host_last = 1'b0; host_data = '0;
    #2;
    chk("reset_state", 32'(curr_state), 32'(ST_IDLE));
    chk("reset_wea", 32'(im_wea), 32'd0);
    chk("reset_addr", 32'(im_addr), 32'd0);
    chk("reset_din", im_din, 32'd0);
    chk("reset_count", 32'(word_count), 32'd0);
    chk("reset_err", 32'(load_err), 32'd0);
    chk("reset_ready", 32'(host_ready), 32'd0);
    @(negedge clk); rst = 1'b0;

`ifndef IMEM_CHECKSUM_EN
    // Back-to-back program, then valid outside LOAD ignored.
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 8'd0, ST_LOAD, 9'd0));
    vecs.push_back(mk(0, 1, 0, 32'h20080005, 1, 8'd0, ST_LOAD, 9'd1));
    vecs.push_back(mk(0, 1, 0, 32'h20090003, 1, 8'd1, ST_LOAD, 9'd2));
    vecs.push_back(mk(0, 1, 1, 32'h00000000, 1, 8'd2, ST_RUN,  9'd3));
    vecs.push_back(mk(0, 1, 0, 32'hDEADBEEF, 0, 8'd2, ST_RUN,  9'd3));
    // Throttled valid over 4 words.
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 8'd2, ST_LOAD, 9'd0));
    vecs.push_back(mk(0, 1, 0, 32'h00000011, 1, 8'd0, ST_LOAD, 9'd1));
    vecs.push_back(mk(0, 0, 0, 32'h00000BAD, 0, 8'd0, ST_LOAD, 9'd1));
    vecs.push_back(mk(0, 1, 0, 32'h00000022, 1, 8'd1, ST_LOAD, 9'd2));
    vecs.push_back(mk(0, 0, 0, 32'h00000BAD, 0, 8'd1, ST_LOAD, 9'd2));
    vecs.push_back(mk(0, 1, 0, 32'h00000033, 1, 8'd2, ST_LOAD, 9'd3));
    vecs.push_back(mk(0, 0, 1, 32'h00000BAD, 0, 8'd2, ST_LOAD, 9'd3));
    vecs.push_back(mk(0, 1, 1, 32'h00000044, 1, 8'd3, ST_RUN,  9'd4));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 8'd3, ST_RUN,  9'd4));
    // Reload from RUN with a single-word program.
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 8'd3, ST_LOAD, 9'd0));
    vecs.push_back(mk(0, 1, 1, 32'h0BADF00D, 1, 8'd0, ST_RUN,  9'd1));
    // start_load in LOAD ignored; start_load with host_last -> RUN.
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 8'd0, ST_LOAD, 9'd0));
    vecs.push_back(mk(1, 1, 0, 32'h00000066, 1, 8'd0, ST_LOAD, 9'd1));
    vecs.push_back(mk(1, 1, 1, 32'h00000077, 1, 8'd1, ST_RUN,  9'd2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 8'd1, ST_RUN,  9'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s, vecs[i].v, vecs[i].l, vecs[i].d);
      $display("vec %0d: s=%0b v=%0b l=%0b d=%h -> wea=%0b addr=%0d st=%0d cnt=%0d", i,
               vecs[i].s, vecs[i].v, vecs[i].l, vecs[i].d, im_wea, im_addr, curr_state, word_count);
      chk($sformatf("vec%0d_wea", i), 32'(im_wea), 32'(vecs[i].wea));
      chk($sformatf("vec%0d_addr", i), 32'(im_addr), 32'(vecs[i].addr));
      if (vecs[i].wea) chk($sformatf("vec%0d_din", i), im_din, vecs[i].din);
      chk($sformatf("vec%0d_state", i), 32'(curr_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_count", i), 32'(word_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_ready", i), 32'(host_ready), 32'(vecs[i].st == ST_LOAD));
      chk($sformatf("vec%0d_err", i), 32'(load_err), 32'd0);
    end
`else
    // Checksum pass: 1+2+3 = 6.
    drive(1, 0, 0, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, (i == 3), 32'(i));
      $display("cks pass beat %0d: wea=%0b addr=%0d st=%0d", i, im_wea, im_addr, curr_state);
      chk("cks_pass_wea", 32'(im_wea), 32'd1);
      chk("cks_pass_addr", 32'(im_addr), 32'(i - 1));
      chk("cks_pass_state", 32'(curr_state), 32'(ST_LOAD));
    end
    drive(0, 1, 0, 32'd6);
    $display("cks pass checksum: wea=%0b st=%0d err=%0b", im_wea, curr_state, load_err);
    chk("cks_pass_wea_sum", 32'(im_wea), 32'd0);
    chk("cks_pass_final", 32'(curr_state), 32'(ST_RUN));
    chk("cks_pass_err", 32'(load_err), 32'd0);
    chk("cks_pass_count", 32'(word_count), 32'd3);
    // Checksum fail: expected 7, IM written exactly 3 times.
    begin
      int writes = 0;
      drive(1, 0, 0, 32'd0);
      for (int i = 1; i <= 3; i++) begin
        drive(0, 1, (i == 3), 32'(i));
        writes += int'(im_wea);
      end
      drive(0, 1, 0, 32'd7);
      writes += int'(im_wea);
      drive(0, 0, 0, 32'd0);
      writes += int'(im_wea);
      $display("cks fail: writes=%0d st=%0d err=%0b", writes, curr_state, load_err);
      chk("cks_fail_writes", 32'(writes), 32'd3);
      chk("cks_fail_state", 32'(curr_state), 32'(ST_ERR));
      chk("cks_fail_err", 32'(load_err), 32'd1);
      chk("cks_fail_count", 32'(word_count), 32'd3);
    end
`endif

    // Overflow: 256 beats with no host_last.
    drive(1, 0, 0, 32'd0);
    chk("ovf_start_state", 32'(curr_state), 32'(ST_LOAD));
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 0, 32'(i) ^ 32'hA5A50000);
      chk("ovf_wea", 32'(im_wea), 32'd1);
      chk("ovf_addr", 32'(im_addr), 32'(i));
      if (i < 255) chk("ovf_state", 32'(curr_state), 32'(ST_LOAD));
    end
    $display("overflow: st=%0d err=%0b cnt=%0d ready=%0b", curr_state, load_err, word_count, host_ready);
    chk("ovf_last_din", im_din, 32'hA5A500FF);
    chk("ovf_err_state", 32'(curr_state), 32'(ST_ERR));
    chk("ovf_err_flag", 32'(load_err), 32'd1);
    chk("ovf_count", 32'(word_count), 32'd256);
    chk("ovf_ready", 32'(host_ready), 32'd0);
    drive(0, 1, 0, 32'h12345678);
    chk("ovf_no_wrap_wea", 32'(im_wea), 32'd0);
    chk("ovf_hold_state", 32'(curr_state), 32'(ST_ERR));
    chk("ovf_hold_count", 32'(word_count), 32'd256);
    drive(1, 0, 0, 32'd0);
    $display("restart after err: st=%0d err=%0b cnt=%0d", curr_state, load_err, word_count);
    chk("restart_state", 32'(curr_state), 32'(ST_LOAD));
    chk("restart_err", 32'(load_err), 32'd0);
    chk("restart_count", 32'(word_count), 32'd0);

    // Async reset while a write strobe is active.
    drive(0, 1, 0, 32'hCAFEF00D);
    chk("pre_rst_wea", 32'(im_wea), 32'd1);
    rst = 1'b1;
    #1;
    $display("mid-load reset: st=%0d wea=%0b ready=%0b", curr_state, im_wea, host_ready);
    chk("rst_mid_state", 32'(curr_state), 32'(ST_IDLE));
    chk("rst_mid_wea", 32'(im_wea), 32'd0);
    chk("rst_mid_addr", 32'(im_addr), 32'd0);
    chk("rst_mid_din", im_din, 32'd0);
    chk("rst_mid_count", 32'(word_count), 32'd0);
    chk("rst_mid_err", 32'(load_err), 32'd0);
    chk("rst_mid_ready", 32'(host_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    drive(0, 1, 0, 32'h1);
    chk("post_rst_idle", 32'(curr_state), 32'(ST_IDLE));
    chk("post_rst_no_write", 32'(im_wea), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
